// File: rtl/quote_egress.sv
// quote_egress
//   Output stage between trading logic and the host register interface.
//   Keeps one pending quote slot per stock. A newer quote for a pending stock
//   replaces the older one, so only the latest quote is emitted. Pending slots
//   are drained round-robin through a valid/ready handshake. After each
//   accepted quote the block waits MIN_GAP idle cycles. Each emitted quote
//   carries a sequence number. Saturating counters record coalesced quotes and
//   rejected (malformed) quotes.
//
// Handshake: o_valid rises with a quote and stays high, with every o_* field
//   stable, until the cycle in which i_ready is high. That cycle is the
//   transfer. i_ready is ignored while o_valid is low.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_data_valid          incoming quote strobe
//   i_stock_id            stock id of the incoming quote
//   i_buy_price           incoming bid
//   i_sell_price          incoming ask
//   i_quantity            incoming quantity
//   i_book_is_busy        blocks new grants while high (sampled in IDLE only)
//   i_ready               downstream accepts the presented quote
//   o_valid               output quote valid
//   o_stock_id            output stock id
//   o_buy_price           output bid
//   o_sell_price          output ask
//   o_quantity            output quantity
//   o_seq                 output sequence number
//   o_coalesce_count      pending quotes overwritten (saturating)
//   o_reject_count        malformed quotes dropped (saturating)
//   o_fsm_state           debug view of the drain FSM (0 IDLE, 1 PRESENT, 2 GAP)
module quote_egress #(
    parameter int NUM_STOCKS = 4,
    parameter int SID_WIDTH  = $clog2(NUM_STOCKS),
    parameter int DATA_WIDTH = 32,
    parameter int QTY_WIDTH  = 32,
    parameter int MIN_GAP    = 2,
    parameter int SEQ_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_data_valid,
    input  logic [SID_WIDTH-1:0]  i_stock_id,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_sell_price,
    input  logic [QTY_WIDTH-1:0]  i_quantity,
    input  logic                  i_book_is_busy,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [SID_WIDTH-1:0]  o_stock_id,
    output logic [DATA_WIDTH-1:0] o_buy_price,
    output logic [DATA_WIDTH-1:0] o_sell_price,
    output logic [QTY_WIDTH-1:0]  o_quantity,
    output logic [SEQ_WIDTH-1:0]  o_seq,
    output logic [CNT_WIDTH-1:0]  o_coalesce_count,
    output logic [CNT_WIDTH-1:0]  o_reject_count,
    output logic [1:0]            o_fsm_state
);

    localparam int PTR_W = $clog2(NUM_STOCKS);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2
    } state_e;

    state_e                  state_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [NUM_STOCKS-1:0]   pending_q, pending_d;
    logic [DATA_WIDTH-1:0]   buy_q  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0]   sell_q [NUM_STOCKS];
    logic [QTY_WIDTH-1:0]    qty_q  [NUM_STOCKS];

    logic                    valid_q;
    logic [SID_WIDTH-1:0]    out_sid_q;
    logic [DATA_WIDTH-1:0]   out_buy_q;
    logic [DATA_WIDTH-1:0]   out_sell_q;
    logic [QTY_WIDTH-1:0]    out_qty_q;
    logic [SEQ_WIDTH-1:0]    seq_q;
    logic [CNT_WIDTH-1:0]    coalesce_q;
    logic [CNT_WIDTH-1:0]    reject_q;

    logic                    in_ok;
    logic                    in_reject;
    logic [PTR_W-1:0]        wr_idx;
    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic                    do_grant;
    logic                    same_slot;

    // Input qualification. The stock id is range-checked before it is
    // narrowed to a slot index, so the truncation below is safe.
    assign in_ok     = i_data_valid && (i_buy_price < i_sell_price) &&
                       (i_quantity != '0) && (32'(i_stock_id) < NUM_STOCKS);
    assign in_reject = i_data_valid && !in_ok;
    assign wr_idx    = PTR_W'(i_stock_id);

    // Round-robin search: the first pending slot at or after rr_ptr, with wrap.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_STOCKS; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_STOCKS;
            cand_idx = PTR_W'(cand);
            if (!grant_found && pending_q[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign do_grant  = (state_q == S_IDLE) && !i_book_is_busy && grant_found;
    assign same_slot = do_grant && in_ok && (wr_idx == grant_idx);
    assign next_ptr  = (grant_idx == PTR_W'(NUM_STOCKS - 1)) ? '0 : grant_idx + PTR_W'(1);

    // The set is applied after the clear. A write to the slot being granted
    // therefore keeps the slot pending with the new data. The output takes the
    // old registered content of that slot.
    always_comb begin
        pending_d = pending_q;
        if (do_grant) pending_d[grant_idx] = 1'b0;
        if (in_ok)    pending_d[wr_idx]    = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                buy_q[s]  <= '0;
                sell_q[s] <= '0;
                qty_q[s]  <= '0;
            end
            valid_q    <= 1'b0;
            out_sid_q  <= '0;
            out_buy_q  <= '0;
            out_sell_q <= '0;
            out_qty_q  <= '0;
            seq_q      <= '0;
            coalesce_q <= '0;
            reject_q   <= '0;
        end else begin
            pending_q <= pending_d;

            if (in_ok) begin
                buy_q[wr_idx]  <= i_buy_price;
                sell_q[wr_idx] <= i_sell_price;
                qty_q[wr_idx]  <= i_quantity;
            end

            // A write that lands on the slot being granted does not count as
            // coalescing. The old quote is still emitted.
            if (in_ok && pending_q[wr_idx] && !same_slot && (coalesce_q != '1))
                coalesce_q <= coalesce_q + CNT_WIDTH'(1);
            if (in_reject && (reject_q != '1))
                reject_q <= reject_q + CNT_WIDTH'(1);

            case (state_q)
                S_IDLE: begin
                    if (do_grant) begin
                        valid_q    <= 1'b1;
                        out_sid_q  <= SID_WIDTH'(grant_idx);
                        out_buy_q  <= buy_q[grant_idx];
                        out_sell_q <= sell_q[grant_idx];
                        out_qty_q  <= qty_q[grant_idx];
                        rr_ptr_q   <= next_ptr;
                        state_q    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (i_ready) begin
                        valid_q   <= 1'b0;
                        seq_q     <= seq_q + SEQ_WIDTH'(1);
                        gap_cnt_q <= '0;
                        state_q   <= (MIN_GAP > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_W'(MIN_GAP - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_valid          = valid_q;
    assign o_stock_id       = out_sid_q;
    assign o_buy_price      = out_buy_q;
    assign o_sell_price     = out_sell_q;
    assign o_quantity       = out_qty_q;
    assign o_seq            = seq_q;
    assign o_coalesce_count = coalesce_q;
    assign o_reject_count   = reject_q;
    assign o_fsm_state      = state_q;

endmodule

// File: tb/tb_quote_egress.sv
// Self-checking bench for quote_egress. Expected quotes are queued when the
// stimulus is driven. A negedge monitor pops and compares them on every
// transfer. Scenario tasks also check timing, stability and counters inline.
module tb_quote_egress;
    localparam int NS  = 4;
    localparam int SW  = 3;   // wide enough to present the illegal id NS
    localparam int DW  = 32;
    localparam int QW  = 32;
    localparam int MG  = 2;
    localparam int QSW = 16;
    localparam int CW  = 16;
    localparam int W   = SW + DW + DW + QW + QSW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dv = 1'b0;
    logic [SW-1:0] sid = '0;
    logic [DW-1:0] buy = '0;
    logic [DW-1:0] sell = '0;
    logic [QW-1:0] qty = '0;
    logic          busy = 1'b0;
    logic          ready = 1'b0;

    logic           o_valid;
    logic [SW-1:0]  o_stock_id;
    logic [DW-1:0]  o_buy_price;
    logic [DW-1:0]  o_sell_price;
    logic [QW-1:0]  o_quantity;
    logic [QSW-1:0] o_seq;
    logic [CW-1:0]  o_coalesce_count;
    logic [CW-1:0]  o_reject_count;
    logic [1:0]     o_fsm_state;

    quote_egress #(
        .NUM_STOCKS(NS), .SID_WIDTH(SW), .DATA_WIDTH(DW), .QTY_WIDTH(QW),
        .MIN_GAP(MG), .SEQ_WIDTH(QSW), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_data_valid(dv), .i_stock_id(sid),
        .i_buy_price(buy), .i_sell_price(sell), .i_quantity(qty),
        .i_book_is_busy(busy), .i_ready(ready),
        .o_valid(o_valid), .o_stock_id(o_stock_id), .o_buy_price(o_buy_price),
        .o_sell_price(o_sell_price), .o_quantity(o_quantity), .o_seq(o_seq),
        .o_coalesce_count(o_coalesce_count), .o_reject_count(o_reject_count),
        .o_fsm_state(o_fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int             checks = 0;
    int             errors = 0;
    int             xfers = 0;
    logic [W-1:0]   exp_q[$];
    int             rise_q[$];
    logic           prev_v = 1'b0;
    logic [QSW-1:0] next_seq = '0;
    logic [W-1:0]   mon_act;
    logic [W-1:0]   mon_exp;

    always @(negedge clk) begin
        if (!rst && o_valid && ready) begin
            checks++;
            xfers++;
            mon_act = {o_stock_id, o_buy_price, o_sell_price, o_quantity, o_seq};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_quote got %h want none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL quote_data got %h want %h", mon_act, mon_exp);
                end
            end
        end
        if (o_valid && !prev_v) rise_q.push_back(cyc);
        prev_v = o_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [SW-1:0] s, input logic [DW-1:0] b,
                            input logic [DW-1:0] se, input logic [QW-1:0] q);
        exp_q.push_back({s, b, se, q, next_seq});
        next_seq++;
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] b,
                        input logic [DW-1:0] se, input logic [QW-1:0] q);
        dv = 1'b1; sid = s; buy = b; sell = se; qty = q;
        tick();
        dv = 1'b0;
        sid = SW'($urandom_range(0, NS - 1));
        buy = $urandom; sell = $urandom; qty = $urandom;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || o_valid) begin
            errors++;
            $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
        end
        repeat (MG + 2) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        next_seq = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_valid !== 1'b0 || o_stock_id !== '0) begin
            errors++;
            $display("FAIL reset_valid_sid got %b/%0d want 0/0", o_valid, o_stock_id);
        end
        checks++;
        if (o_buy_price !== '0 || o_sell_price !== '0 || o_quantity !== '0) begin
            errors++;
            $display("FAIL reset_fields got %0d/%0d/%0d want 0/0/0",
                     o_buy_price, o_sell_price, o_quantity);
        end
        checks++;
        if (o_seq !== '0 || o_coalesce_count !== '0 || o_reject_count !== '0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0",
                     o_seq, o_coalesce_count, o_reject_count);
        end
        rst = 1'b0;
        next_seq = '0;
        tick();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        busy  = 1'b0;
        push_exp(3'd1, 100, 102, 10);
        send(3'd1, 100, 102, 10);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early got %b want 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_stock_id !== 3'd1 || o_seq !== 16'd0) begin
            errors++;
            $display("FAIL basic_latency got v=%b sid=%0d seq=%0d want v=1 sid=1 seq=0",
                     o_valid, o_stock_id, o_seq);
        end
        wait_drain(20);
        push_exp(3'd3, 500, 600, 1);
        send(3'd3, 500, 600, 1);
        wait_drain(20);
    endtask

    task automatic test_coalesce();
        int x0;
        int saw_v;
        busy = 1'b1;
        ready = 1'b1;
        send(3'd2, 50, 60, 5);
        send(3'd2, 51, 60, 5);
        send(3'd2, 52, 60, 5);
        checks++;
        if (o_coalesce_count !== 16'd2) begin
            errors++;
            $display("FAIL coalesce_count got %0d want 2", o_coalesce_count);
        end
        saw_v = 0;
        repeat (3) begin
            tick();
            if (o_valid) saw_v++;
        end
        checks++;
        if (saw_v != 0) begin
            errors++;
            $display("FAIL busy_blocks got %0d valid cycles want 0", saw_v);
        end
        x0 = xfers;
        push_exp(3'd2, 52, 60, 5);
        busy = 1'b0;
        wait_drain(30);
        repeat (4) tick();
        checks++;
        if (xfers != x0 + 1) begin
            errors++;
            $display("FAIL coalesce_single got %0d quotes want 1", xfers - x0);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        ready = 1'b1;
        busy  = 1'b1;
        send(3'd3, 30, 31, 3);
        send(3'd0, 10, 11, 1);
        send(3'd1, 20, 21, 2);
        push_exp(3'd0, 10, 11, 1);
        push_exp(3'd1, 20, 21, 2);
        push_exp(3'd3, 30, 31, 3);
        rise_q.delete();
        busy = 1'b0;
        wait_drain(60);
        checks++;
        if (rise_q.size() != 3) begin
            errors++;
            $display("FAIL rr_rise_count got %0d want 3", rise_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rise_q[i] - rise_q[i-1] != 4) begin
                    errors++;
                    $display("FAIL rr_spacing got %0d want 4", rise_q[i] - rise_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hold_exp;
        int n;
        ready = 1'b0;
        busy  = 1'b0;
        push_exp(3'd0, 10, 20, 3);
        hold_exp = exp_q[0];
        send(3'd0, 10, 20, 3);
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_present got %b want 1", o_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                push_exp(3'd0, 7, 20, 3);
                send(3'd0, 7, 20, 3);
            end else begin
                tick();
            end
            checks++;
            if (o_valid !== 1'b1 ||
                {o_stock_id, o_buy_price, o_sell_price, o_quantity, o_seq} !== hold_exp) begin
                errors++;
                $display("FAIL bp_stable got v=%b %h want v=1 %h", o_valid,
                         {o_stock_id, o_buy_price, o_sell_price, o_quantity, o_seq}, hold_exp);
            end
        end
        ready = 1'b1;
        wait_drain(40);
        checks++;
        if (o_coalesce_count !== 16'd0) begin
            errors++;
            $display("FAIL bp_no_coalesce got %0d want 0", o_coalesce_count);
        end
    endtask

    task automatic test_rejects();
        int x0;
        int saw_v;
        ready = 1'b1;
        busy  = 1'b0;
        x0 = xfers;
        send(3'd1, 200, 200, 5);
        send(3'd1, 10, 20, 0);
        send(3'(NS), 10, 20, 5);
        saw_v = 0;
        repeat (5) begin
            tick();
            if (o_valid) saw_v++;
        end
        checks++;
        if (saw_v != 0 || xfers != x0) begin
            errors++;
            $display("FAIL reject_no_output got %0d valid cycles want 0", saw_v);
        end
        checks++;
        if (o_reject_count !== 16'd3) begin
            errors++;
            $display("FAIL reject_count got %0d want 3", o_reject_count);
        end
        // buy one below sell is the tightest legal spread
        push_exp(3'd2, 199, 200, 1);
        send(3'd2, 199, 200, 1);
        wait_drain(30);
        checks++;
        if (o_reject_count !== 16'd3) begin
            errors++;
            $display("FAIL reject_edge_accept got %0d want 3", o_reject_count);
        end
    endtask

    task automatic test_same_slot_grant();
        ready = 1'b1;
        busy  = 1'b1;
        push_exp(3'd1, 40, 45, 7);
        send(3'd1, 40, 45, 7);
        busy = 1'b0;
        push_exp(3'd1, 41, 45, 7);
        send(3'd1, 41, 45, 7);
        checks++;
        if (o_coalesce_count !== 16'd0) begin
            errors++;
            $display("FAIL same_slot_coalesce got %0d want 0", o_coalesce_count);
        end
        wait_drain(40);
    endtask

    task automatic test_mid_reset();
        int x0;
        int saw_v;
        int n;
        ready = 1'b0;
        busy  = 1'b0;
        send(3'd0, 11, 12, 4);
        send(3'd2, 21, 22, 4);
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_present got %b want 1", o_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_stock_id !== '0 || o_buy_price !== '0 ||
            o_sell_price !== '0 || o_quantity !== '0 || o_seq !== '0 ||
            o_coalesce_count !== '0 || o_reject_count !== '0) begin
            errors++;
            $display("FAIL mid_reset_clear got v=%b sid=%0d seq=%0d want all 0",
                     o_valid, o_stock_id, o_seq);
        end
        rst = 1'b0;
        next_seq = '0;
        ready = 1'b1;
        x0 = xfers;
        saw_v = 0;
        repeat (20) begin
            tick();
            if (o_valid) saw_v++;
        end
        checks++;
        if (saw_v != 0 || xfers != x0) begin
            errors++;
            $display("FAIL mid_reset_quiet got %0d valid cycles want 0", saw_v);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_coalesce();
        test_round_robin();
        test_backpressure();
        test_rejects();
        test_same_slot_grant();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
